// File: rtl/decode_writeback.sv
// Y86-64 decode/writeback stage: source/destination selection, 15-entry register file,
// condition-code register and the RUN/HALT state machine.
module decode_writeback (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  icode,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic        cnd,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    input  logic        wb_en,
    input  logic [2:0]  new_CC,
    output logic [63:0] valA,
    output logic [63:0] valB,
    output logic [2:0]  cc,
    output logic        halted,
    input  logic [3:0]  dbg_sel,
    output logic [63:0] dbg_val
);

    localparam logic [3:0] R_NONE  = 4'hF;
    localparam logic [3:0] R_RSP   = 4'h4;

    localparam logic [3:0] I_HALT  = 4'h0;
    localparam logic [3:0] I_RRMOV = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OP    = 4'h6;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [63:0] regs_q [0:14];
    logic [63:0] regs_d [0:14];
    logic [2:0]  cc_q;
    logic [2:0]  cc_d;
    logic [3:0]  src_a_s;
    logic [3:0]  src_b_s;
    logic [3:0]  dst_e_s;
    logic [3:0]  dst_m_s;
    logic        commit_s;

    // Operand and destination register selection from the instruction code.
    always_comb begin
        src_a_s = R_NONE;
        src_b_s = R_NONE;
        dst_e_s = R_NONE;
        dst_m_s = R_NONE;
        case (icode)
            I_RRMOV: begin
                src_a_s = rA;
                if (cnd) begin
                    dst_e_s = rB;
                end else begin
                    dst_e_s = R_NONE;
                end
            end
            I_IRMOV: dst_e_s = rB;
            I_RMMOV: begin
                src_a_s = rA;
                src_b_s = rB;
            end
            I_MRMOV: begin
                src_b_s = rB;
                dst_m_s = rA;
            end
            I_OP: begin
                src_a_s = rA;
                src_b_s = rB;
                dst_e_s = rB;
            end
            I_CALL: begin
                src_b_s = R_RSP;
                dst_e_s = R_RSP;
            end
            I_RET: begin
                src_a_s = R_RSP;
                src_b_s = R_RSP;
                dst_e_s = R_RSP;
            end
            I_PUSH: begin
                src_a_s = rA;
                src_b_s = R_RSP;
                dst_e_s = R_RSP;
            end
            I_POP: begin
                src_a_s = R_RSP;
                src_b_s = R_RSP;
                dst_e_s = R_RSP;
                dst_m_s = rA;
            end
            default: begin
                src_a_s = R_NONE;
                src_b_s = R_NONE;
                dst_e_s = R_NONE;
                dst_m_s = R_NONE;
            end
        endcase
    end

    // Reads see only the registered file; same-cycle writes appear on the next cycle.
    assign valA    = (src_a_s == R_NONE) ? 64'd0 : regs_q[src_a_s];
    assign valB    = (src_b_s == R_NONE) ? 64'd0 : regs_q[src_b_s];
    assign dbg_val = (dbg_sel == R_NONE) ? 64'd0 : regs_q[dbg_sel];
    assign cc      = cc_q;
    assign halted  = (state_q == S_HALT);

    assign commit_s = wb_en && (state_q == S_RUN);

    // Next-state for the register file, flags and run state; the valM write is applied last so it wins.
    always_comb begin
        for (int i = 0; i < 15; i++) begin
            regs_d[i] = regs_q[i];
        end
        cc_d    = cc_q;
        state_d = state_q;
        if (commit_s) begin
            if (dst_e_s != R_NONE) begin
                regs_d[dst_e_s] = valE;
            end else begin
                regs_d[0] = regs_d[0];
            end
            if (dst_m_s != R_NONE) begin
                regs_d[dst_m_s] = valM;
            end else begin
                regs_d[0] = regs_d[0];
            end
            if (icode == I_OP) begin
                cc_d = new_CC;
            end else begin
                cc_d = cc_q;
            end
            if (icode == I_HALT) begin
                state_d = S_HALT;
            end else begin
                state_d = state_q;
            end
        end else begin
            state_d = state_q;
        end
    end

    // State registers with synchronous reset taking priority over any commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 15; i++) begin
                regs_q[i] <= 64'd0;
            end
            cc_q    <= 3'b001;
            state_q <= S_RUN;
        end else begin
            for (int i = 0; i < 15; i++) begin
                regs_q[i] <= regs_d[i];
            end
            cc_q    <= cc_d;
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_decode_writeback.sv
// Directed bench for decode_writeback: each step drives inputs, clocks once and checks
// outputs against hand-computed values.
module tb_decode_writeback;

    logic        clk;
    logic        rst;
    logic [3:0]  icode;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic        cnd;
    logic [63:0] valE;
    logic [63:0] valM;
    logic        wb_en;
    logic [2:0]  new_CC;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [2:0]  cc;
    logic        halted;
    logic [3:0]  dbg_sel;
    logic [63:0] dbg_val;

    int checks = 0;
    int errors = 0;

    decode_writeback dut (
        .clk     (clk),
        .rst     (rst),
        .icode   (icode),
        .rA      (rA),
        .rB      (rB),
        .cnd     (cnd),
        .valE    (valE),
        .valM    (valM),
        .wb_en   (wb_en),
        .new_CC  (new_CC),
        .valA    (valA),
        .valB    (valB),
        .cc      (cc),
        .halted  (halted),
        .dbg_sel (dbg_sel),
        .dbg_val (dbg_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd_dbg(input string tag, input logic [3:0] sel, input logic [63:0] exp);
        dbg_sel = sel;
        #1;
        chk(tag, dbg_val, exp);
    endtask

    // Single committed writeback of one instruction, leaving wb_en low afterwards.
    task automatic commit(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                          input logic [63:0] ve, input logic [63:0] vm);
        icode = ic; rA = ra; rB = rb; valE = ve; valM = vm; wb_en = 1'b1;
        step();
        wb_en = 1'b0;
        icode = 4'h1;
        #1;
    endtask

    initial begin
        rst = 1'b1; icode = 4'h1; rA = 4'hF; rB = 4'hF; cnd = 1'b0;
        valE = 64'd0; valM = 64'd0; wb_en = 1'b0; new_CC = 3'b000; dbg_sel = 4'h0;
        step();
        step();
        rst = 1'b0;
        #1;

        chk("rst_halted", {63'd0, halted}, 64'd0);
        chk("rst_cc", {61'd0, cc}, 64'd1);
        rd_dbg("rst_dbg0", 4'h0, 64'd0);
        rd_dbg("rst_dbg4", 4'h4, 64'd0);
        rd_dbg("rst_dbg14", 4'hE, 64'd0);
        rd_dbg("rst_dbgF", 4'hF, 64'd0);
        icode = 4'h6; rA = 4'h3; rB = 4'h7; #1;
        chk("rst_valA", valA, 64'd0);
        chk("rst_valB", valB, 64'd0);

        // irmovq $0x1234, %rdx
        commit(4'h3, 4'hF, 4'h2, 64'h1234, 64'd0);
        rd_dbg("irmov_dbg2", 4'h2, 64'h1234);
        icode = 4'h6; rA = 4'h2; rB = 4'hF; #1;
        chk("irmov_valA", valA, 64'h1234);
        chk("none_valB", valB, 64'd0);

        // cmov gated by cnd
        cnd = 1'b0;
        commit(4'h2, 4'h2, 4'h5, 64'd7, 64'd0);
        rd_dbg("cmov_cnd0", 4'h5, 64'd0);
        cnd = 1'b1;
        commit(4'h2, 4'h2, 4'h5, 64'd7, 64'd0);
        rd_dbg("cmov_cnd1", 4'h5, 64'd7);
        cnd = 1'b0;

        // popq %rsp: valM wins over valE
        commit(4'h3, 4'hF, 4'h4, 64'h100, 64'd0);
        icode = 4'hB; rA = 4'h4; #1;
        chk("pop_valA_rsp", valA, 64'h100);
        chk("pop_valB_rsp", valB, 64'h100);
        commit(4'hB, 4'h4, 4'hF, 64'h108, 64'hAA);
        rd_dbg("pop_rsp", 4'h4, 64'hAA);

        // mrmovq writes valM to rA; pushq writes valE to rsp
        commit(4'h5, 4'h6, 4'h2, 64'h9999, 64'h55);
        rd_dbg("mrmov_r6", 4'h6, 64'h55);
        rd_dbg("mrmov_r2_kept", 4'h2, 64'h1234);
        commit(4'hA, 4'h6, 4'hF, 64'hA0, 64'h77);
        rd_dbg("push_rsp", 4'h4, 64'hA0);

        // Condition codes
        new_CC = 3'b110;
        commit(4'h6, 4'hF, 4'hF, 64'd0, 64'd0);
        chk("cc_op", {61'd0, cc}, 64'd6);
        new_CC = 3'b001;
        commit(4'h3, 4'hF, 4'hF, 64'd0, 64'd0);
        chk("cc_hold_irmov", {61'd0, cc}, 64'd6);
        icode = 4'h6; new_CC = 3'b011; wb_en = 1'b0;
        step();
        chk("cc_hold_nowb", {61'd0, cc}, 64'd6);

        // Same-cycle read/write returns old value
        commit(4'h3, 4'hF, 4'h1, 64'd5, 64'd0);
        icode = 4'h6; rA = 4'h1; rB = 4'h1; valE = 64'd9; new_CC = 3'b110; wb_en = 1'b1;
        #1;
        chk("rw_old", valA, 64'd5);
        step();
        wb_en = 1'b0;
        #1;
        chk("rw_new", valA, 64'd9);

        // Undefined / no-op icodes write nothing
        commit(4'h7, 4'h2, 4'h2, 64'hDEAD, 64'hBEEF);
        rd_dbg("icode7_r2", 4'h2, 64'h1234);
        commit(4'hC, 4'h2, 4'h2, 64'hDEAD, 64'hBEEF);
        rd_dbg("icodeC_r2", 4'h2, 64'h1234);
        commit(4'h1, 4'h2, 4'h2, 64'hDEAD, 64'hBEEF);
        rd_dbg("nop_r2", 4'h2, 64'h1234);
        chk("nop_halted", {63'd0, halted}, 64'd0);

        // Halt blocks further writes; halting instruction writes nothing
        commit(4'h3, 4'hF, 4'h3, 64'h33, 64'd0);
        rd_dbg("pre_halt_r3", 4'h3, 64'h33);
        commit(4'h0, 4'h3, 4'h3, 64'h44, 64'h45);
        chk("halt_set", {63'd0, halted}, 64'd1);
        rd_dbg("halt_nowrite", 4'h3, 64'h33);
        commit(4'h3, 4'hF, 4'h3, 64'h77, 64'd0);
        rd_dbg("halt_block_reg", 4'h3, 64'h33);
        new_CC = 3'b011;
        commit(4'h6, 4'hF, 4'hF, 64'd0, 64'd0);
        chk("halt_block_cc", {61'd0, cc}, 64'd6);
        chk("halt_sticky", {63'd0, halted}, 64'd1);

        // Reset wins over a simultaneous commit
        rst = 1'b1; icode = 4'h3; rB = 4'h3; valE = 64'h99; wb_en = 1'b1;
        step();
        rst = 1'b0; wb_en = 1'b0; icode = 4'h1;
        #1;
        chk("rst_halted_clr", {63'd0, halted}, 64'd0);
        chk("rst_cc_again", {61'd0, cc}, 64'd1);
        rd_dbg("rst_r3", 4'h3, 64'd0);
        rd_dbg("rst_r2", 4'h2, 64'd0);

        // Reset pre-empts a halt on the same edge
        rst = 1'b1; icode = 4'h0; wb_en = 1'b1;
        step();
        rst = 1'b0; wb_en = 1'b0; icode = 4'h1;
        #1;
        chk("rst_over_halt", {63'd0, halted}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_writeback.md
DECODE_WRITEBACK -- requirements
Module: decode_writeback

Interface
REQ-001 The block SHALL have the port `clk`: input, 1 bit; the single clock, with all state updating on its rising edge.
REQ-002 The block SHALL have the port `rst`: input, 1 bit; synchronous, active-high reset.
REQ-003 The block SHALL have the port `icode`: input, 4 bits; instruction code of the instruction in decode/writeback.
REQ-004 The block SHALL have the ports `rA` and `rB`: input, 4 bits each; register specifiers, where 4'hF means none.
REQ-005 The block SHALL have the port `cnd`: input, 1 bit; condition result from execute, gating the rrmovq/cmovXX write.
REQ-006 The block SHALL have the ports `valE` and `valM`: input, 64 bits each; ALU result and memory read data to be written back.
REQ-007 The block SHALL have the port `wb_en`: input, 1 bit; when high, the current instruction commits its writeback on this edge.
REQ-008 The block SHALL have the port `new_CC`: input, 3 bits; flags from execute, with [0]=ZF, [1]=SF, [2]=OF.
REQ-009 The block SHALL have the ports `valA` and `valB`: output, 64 bits each; register operands presented to execute.
REQ-010 The block SHALL have the port `cc`: output, 3 bits; registered condition codes with the same bit map as `new_CC`, feeding execute's flag input.
REQ-011 The block SHALL have the port `halted`: output, 1 bit; high once a halt has committed.
REQ-012 The block SHALL have the ports `dbg_sel` (input, 4 bits) and `dbg_val` (output, 64 bits); combinational debug read of register `dbg_sel`.

Function
REQ-013 The block SHALL hold a register file of 15 x 64-bit registers, indices 0-14, with 4 = %rsp.
REQ-014 Read ports (`valA`, `valB`, `dbg_val`) SHALL be combinational, and reading index 4'hF SHALL return 0.
REQ-015 srcA SHALL be: rA for icode 2, 4, 6 and A; register 4 for icode 9 and B; none otherwise.
REQ-016 srcB SHALL be: rB for icode 4, 5 and 6; register 4 for icode 8, 9, A and B; none otherwise.
REQ-017 dstE SHALL be: rB for icode 3 and 6; rB for icode 2 only when `cnd`=1; register 4 for icode 8, 9, A and B; none otherwise.
REQ-018 dstM SHALL be: rA for icode 5 and B; none otherwise.
REQ-019 On a rising edge with `wb_en`=1 and `halted`=0, the block SHALL write `valE` to dstE and `valM` to dstM; a destination of none SHALL write nothing.
REQ-020 When dstE equals dstM (for example popq %rsp), the `valM` write SHALL win.
REQ-021 A read and a write to the same register in the same cycle SHALL return the old value, with no internal bypass; the new value SHALL be visible in the following cycle.
REQ-022 `cc` SHALL load `new_CC` on an edge with `wb_en`=1, icode=6 and `halted`=0, and SHALL hold otherwise.
REQ-023 The block SHALL implement a two-state machine, RUN and HALT: RUN->HALT on an edge with `wb_en`=1 and icode=0; HALT is left only by reset.
REQ-024 `halted` SHALL be 1 exactly in HALT, and in HALT all register and `cc` writes SHALL be blocked.
REQ-025 The halting instruction SHALL itself write nothing.
REQ-026 Write latency SHALL be 1 cycle, and `cc` latency SHALL be 1 cycle.
REQ-027 icode values 1, 7 and C-F SHALL write nothing and SHALL not alter state.
REQ-028 Register values SHALL wrap at 64 bits, and the block SHALL perform no arithmetic.

Reset
REQ-029 On a rising edge with `rst`=1, all 15 registers SHALL become 0, `cc` SHALL become 3'b001 (ZF=1), and the state SHALL become RUN with `halted`=0.
REQ-030 `rst` SHALL have priority over any simultaneous writeback or halt.
REQ-031 Reset asserted mid-operation or while in HALT SHALL take effect on that edge.
REQ-032 After reset, `valA`, `valB` and `dbg_val` SHALL read 0 for any select.

Verification
REQ-033 irmovq: reset; icode=3, rB=2, `valE`=64'h1234, `wb_en`=1 for 1 edge -> next cycle `dbg_sel`=2 gives 64'h1234, and icode=6 with rA=2 gives `valA`=64'h1234.
REQ-034 cmov gating: icode=2, rB=5, `valE`=7, `cnd`=0 -> r5 stays 0; repeat with `cnd`=1 -> r5=7.
REQ-035 popq %rsp: r4 preloaded to 64'h100; icode=B, rA=4, `valE`=64'h108, `valM`=64'hAA -> r4=64'hAA.
REQ-036 CC update: icode=6, `new_CC`=3'b110 -> `cc`=3'b110 next cycle; icode=3 with `new_CC`=3'b001 -> `cc` holds 3'b110.
REQ-037 Halt: icode=0, `wb_en`=1 -> `halted`=1; a later irmovq to r3 -> r3 unchanged; `rst` pulse -> `halted`=0, `cc`=3'b001 and r3=0.
REQ-038 Same-cycle read/write: r1=5, icode=6, rA=1, rB=1, `valE`=9 -> `valA`=5 during the write cycle and 9 in the next cycle.
